// File: rtl/la_iorxdiff_filter_pkg.sv
// rtl/la_iorxdiff_filter_pkg.sv - shared state encoding and defaults for the diff receiver filter
package la_iorxdiff_filter_pkg;

    typedef enum logic [1:0] {
        LA_RXF_OFF    = 2'd0,
        LA_RXF_WAKE   = 2'd1,
        LA_RXF_ACTIVE = 2'd2,
        LA_RXF_FAULT  = 2'd3
    } la_rxf_state_e;

    localparam int LA_RXF_SYNCW_DEF   = 2;
    localparam int LA_RXF_WAKECNT_DEF = 4;

    // The receiver pair is only meaningful when its two outputs disagree.
    function automatic logic la_rxf_legal(input logic p, input logic n);
        return p ^ n;
    endfunction

endpackage

// File: rtl/la_rxdiff_sync.sv
// rtl/la_rxdiff_sync.sv - SYNCW-deep single-bit synchroniser for an asynchronous receiver output
module la_rxdiff_sync #(
    parameter int SYNCW = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic [SYNCW-1:0] ff_q;
    logic [SYNCW-1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[SYNCW-2:0], d};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[SYNCW-1];

endmodule

// File: rtl/la_iorxdiff_filter.sv
// rtl/la_iorxdiff_filter.sv - enable sequencing, glitch filter and fault detection for a diff receiver
module la_iorxdiff_filter
    import la_iorxdiff_filter_pkg::*;
#(
    parameter int SYNCW    = LA_RXF_SYNCW_DEF,
    parameter int FILTW    = 4,
    parameter int FAULTW   = 4,
    parameter int FAULTCNT = 8,
    parameter int WAKECNT  = LA_RXF_WAKECNT_DEF
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic [FILTW-1:0] thresh,
    input  logic             fault_clr,
    input  logic             zp,
    input  logic             zn,
    output logic             ie,
    output logic             z,
    output logic             rise,
    output logic             fall,
    output logic             valid,
    output logic             fault
);

    localparam int WAKEW = $clog2(WAKECNT + SYNCW);
    localparam logic [WAKEW-1:0]  WAKE_LAST  = WAKEW'(WAKECNT + SYNCW - 1);
    localparam logic [FAULTW-1:0] FAULT_LAST = FAULTW'(FAULTCNT - 1);

    logic zp_s;
    logic zn_s;

    la_rxdiff_sync #(.SYNCW(SYNCW)) u_sync_p (.clk(clk), .nreset(nreset), .d(zp), .q(zp_s));
    la_rxdiff_sync #(.SYNCW(SYNCW)) u_sync_n (.clk(clk), .nreset(nreset), .d(zn), .q(zn_s));

    la_rxf_state_e     state_q, state_d;
    logic [WAKEW-1:0]  wake_q, wake_d;
    logic [FILTW-1:0]  filt_q, filt_d;
    logic [FAULTW-1:0] inv_q, inv_d;
    logic              z_q, z_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              legal;

    always_comb begin
        state_d = state_q;
        wake_d  = wake_q;
        filt_d  = filt_q;
        inv_d   = inv_q;
        z_d     = z_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        legal   = la_rxf_legal(zp_s, zn_s);

        if (!en) begin
            state_d = LA_RXF_OFF;
            wake_d  = '0;
            filt_d  = '0;
            inv_d   = '0;
        end else begin
            case (state_q)
                LA_RXF_OFF: begin
                    state_d = LA_RXF_WAKE;
                    wake_d  = '0;
                    filt_d  = '0;
                    inv_d   = '0;
                end
                LA_RXF_WAKE: begin
                    filt_d = '0;
                    inv_d  = '0;
                    if (wake_q == WAKE_LAST) begin
                        state_d = LA_RXF_ACTIVE;
                        wake_d  = '0;
                    end else begin
                        wake_d = wake_q + 1'b1;
                    end
                end
                LA_RXF_ACTIVE: begin
                    if (!legal) begin
                        filt_d = '0;
                        if (inv_q == FAULT_LAST) begin
                            state_d = LA_RXF_FAULT;
                            inv_d   = '0;
                        end else if (inv_q != '1) begin
                            inv_d = inv_q + 1'b1;
                        end
                    end else begin
                        inv_d = '0;
                        // >= keeps a count above a freshly lowered thresh from running on
                        if (zp_s != z_q) begin
                            if (filt_q >= thresh) begin
                                z_d    = zp_s;
                                rise_d = zp_s;
                                fall_d = ~zp_s;
                                filt_d = '0;
                            end else begin
                                filt_d = filt_q + 1'b1;
                            end
                        end else begin
                            filt_d = '0;
                        end
                    end
                end
                LA_RXF_FAULT: begin
                    filt_d = '0;
                    inv_d  = '0;
                    if (fault_clr) begin
                        state_d = LA_RXF_WAKE;
                        wake_d  = '0;
                    end
                end
                default: state_d = LA_RXF_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= LA_RXF_OFF;
            wake_q  <= '0;
            filt_q  <= '0;
            inv_q   <= '0;
            z_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wake_q  <= wake_d;
            filt_q  <= filt_d;
            inv_q   <= inv_d;
            z_q     <= z_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign ie    = (state_q != LA_RXF_OFF);
    assign valid = (state_q == LA_RXF_ACTIVE);
    assign fault = (state_q == LA_RXF_FAULT);
    assign z     = z_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_la_iorxdiff_filter.sv
// tb/tb_la_iorxdiff_filter.sv - scenario tasks with an expected-output queue per clock
module tb_la_iorxdiff_filter;

    typedef struct packed {
        logic ie;
        logic valid;
        logic fault;
        logic z;
        logic rise;
        logic fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       nreset;
    logic       en;
    logic [3:0] thresh;
    logic       fault_clr;
    logic       zp;
    logic       zn;
    logic       ie, z, rise, fall, valid, fault;

    exp_t exp_q[$];
    exp_t e;
    exp_t got;
    int   n_vec = 0;
    int   n_err = 0;

    la_iorxdiff_filter dut (
        .clk(clk), .nreset(nreset), .en(en), .thresh(thresh), .fault_clr(fault_clr),
        .zp(zp), .zn(zn), .ie(ie), .z(z), .rise(rise), .fall(fall), .valid(valid), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic i, input logic v, input logic f,
                                input logic zz, input logic r, input logic fl);
        exp_t x;
        x = '{ie: i, valid: v, fault: f, z: zz, rise: r, fall: fl};
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; en = 1'b1; zp = 1'b0; zn = 1'b1; thresh = 4'd0; fault_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL reset_hold got=%b exp=%b", got, e); end
        end
        nreset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back(mk(1, k >= 7, 0, 0, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL wake k=%0d got=%b exp=%b", k, got, e); end
        end
        zp = 1'b1; zn = 1'b0;
        for (int m = 1; m <= 5; m++) begin
            exp_q.push_back(mk(1, 1, 0, m >= 3, m == 3, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL rise_latency m=%0d got=%b exp=%b", m, got, e); end
        end
    endtask

    task automatic test_filter();
        thresh = 4'd3; zp = 1'b0; zn = 1'b1;
        for (int m = 1; m <= 10; m++) begin
            exp_q.push_back(mk(1, 1, 0, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL glitch_reject m=%0d got=%b exp=%b", m, got, e); end
            if (m == 3) begin zp = 1'b1; zn = 1'b0; end
        end
        zp = 1'b0; zn = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            exp_q.push_back(mk(1, 1, 0, m < 6, 0, m == 6));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL fall_latency m=%0d got=%b exp=%b", m, got, e); end
        end
    endtask

    task automatic test_invalid();
        thresh = 4'd0; zp = 1'b1; zn = 1'b0;
        for (int m = 1; m <= 5; m++) begin
            exp_q.push_back(mk(1, 1, 0, m >= 3, m == 3, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL rerise m=%0d got=%b exp=%b", m, got, e); end
        end
        zn = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            exp_q.push_back(mk(1, 1, 0, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL invalid_7 m=%0d got=%b exp=%b", m, got, e); end
            if (m == 7) zn = 1'b0;
        end
        zp = 1'b0; zn = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            exp_q.push_back(mk(1, m < 10, m >= 10, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL invalid_8 m=%0d got=%b exp=%b", m, got, e); end
        end
    endtask

    task automatic test_fault_clr();
        fault_clr = 1'b1; zp = 1'b1; zn = 1'b0;
        for (int m = 1; m <= 8; m++) begin
            exp_q.push_back(mk(1, m >= 7, 0, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL clr_rewake m=%0d got=%b exp=%b", m, got, e); end
            fault_clr = 1'b0;
        end
        zp = 1'b0; zn = 1'b0;
        for (int m = 1; m <= 10; m++) begin
            exp_q.push_back(mk(1, m < 10, m >= 10, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL refault m=%0d got=%b exp=%b", m, got, e); end
        end
        en = 1'b0; fault_clr = 1'b1;
        for (int m = 1; m <= 3; m++) begin
            exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL clr_off m=%0d got=%b exp=%b", m, got, e); end
        end
        fault_clr = 1'b0; zp = 1'b1; zn = 1'b0;
    endtask

    task automatic test_en_drop();
        en = 1'b1; thresh = 4'd5;
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back(mk(1, k >= 7, 0, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL en_wake k=%0d got=%b exp=%b", k, got, e); end
        end
        zp = 1'b0; zn = 1'b1;
        for (int m = 1; m <= 5; m++) begin
            exp_q.push_back(mk(1, 1, 0, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL pre_drop m=%0d got=%b exp=%b", m, got, e); end
        end
        en = 1'b0;
        for (int m = 1; m <= 2; m++) begin
            exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL en_drop m=%0d got=%b exp=%b", m, got, e); end
        end
        en = 1'b1;
        for (int r = 1; r <= 14; r++) begin
            exp_q.push_back(mk(1, r >= 7, 0, r < 13, 0, r == 13));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL count_restart r=%0d got=%b exp=%b", r, got, e); end
        end
    endtask

    task automatic test_async_reset();
        thresh = 4'd0; zp = 1'b1; zn = 1'b0;
        for (int m = 1; m <= 5; m++) begin
            exp_q.push_back(mk(1, 1, 0, m >= 3, m == 3, 0));
            tick();
            got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL pre_areset m=%0d got=%b exp=%b", m, got, e); end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        #2;
        nreset = 1'b0;
        #1;
        got = {ie, valid, fault, z, rise, fall}; e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_err++; $display("FAIL async_reset got=%b exp=%b", got, e); end
        tick();
        nreset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_filter();
        test_invalid();
        test_fault_clr();
        test_en_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
